inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader_pkg.sv | 31 +++
 rtl/inst_loader_btn_debounce.sv | 51 +++++
 rtl/inst_loader.sv | 118 +++++++++++
 tb/tb_inst_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_loader_pkg
// Brief    : Shared state encoding, word geometry and byte-insert helper.
// Revision : 1.0 - initial release
// ============================================================================
package inst_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle    = 2'd0;
    localparam state_t c_st_collect = 2'd1;
    localparam state_t c_st_write   = 2'd2;
    localparam state_t c_st_full    = 2'd3;

    localparam logic [1:0] c_last_byte = 2'(BYTES_PER_WORD - 1);

    // Byte 0 lands in [7:0], byte 3 in [31:24].
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  data);
        logic [31:0] result;
        result = word;
        result[{idx, 3'b000} +: 8] = data;
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_loader_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : 2-flop synchronizer, stability-count debouncer, rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DB_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);

    localparam logic [15:0] c_cnt_max = 16'(DB_CYC - 1);

    logic        r_sync0;
    logic        r_sync1;
    logic        r_level;
    logic        r_level_d;
    logic [15:0] r_cnt;

    // r_cnt counts consecutive synchronized samples that disagree with the
    // debounced level; the DB_CYC-th such sample adopts the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0   <= 1'b0;
            r_sync1   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync0   <= btn_raw;
            r_sync1   <= r_sync0;
            r_level_d <= r_level;
            if (r_sync1 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_level <= r_sync1;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign pulse = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_loader
// Brief    : Assembles four switch bytes per button commit into 32-bit words
//            and writes them to consecutive instruction-memory addresses.
// Revision : 1.0 - initial release
// ============================================================================
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DB_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        sw,
    input  logic              btn,
    input  logic              load_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [1:0]        byte_idx,
    output logic [7:0]        led,
    output logic              full
);

    localparam logic [ADDR_W-1:0] c_addr_last = '1;

    logic              w_commit;
    logic [31:0]       w_word_next;

    state_t            r_state;
    logic [1:0]        r_byte_idx;
    logic [31:0]       r_word;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic              r_full;
    logic [7:0]        r_led;

    btn_debounce #(
        .DB_CYC (DB_CYC)
    ) u_btn_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn),
        .pulse   (w_commit)
    );

    assign w_word_next = insert_byte(r_word, r_byte_idx, sw);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_byte_idx <= 2'd0;
            r_word     <= '0;
            r_wdata    <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_full     <= 1'b0;
            r_led      <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_byte_idx <= 2'd0;
                    if (load_en) begin
                        r_state <= c_st_collect;
                    end
                end
                c_st_collect: begin
                    if (!load_en) begin
                        r_state    <= c_st_idle;
                        r_byte_idx <= 2'd0;
                        r_word     <= '0;
                    end else if (w_commit) begin
                        r_word <= w_word_next;
                        r_led  <= sw;
                        if (r_byte_idx == c_last_byte) begin
                            r_byte_idx <= 2'd0;
                            r_wdata    <= w_word_next;
                            r_we       <= 1'b1;
                            r_state    <= c_st_write;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                    end
                end
                c_st_write: begin
                    // The write is already on the bus; only the exit is decided here.
                    if (r_addr == c_addr_last) begin
                        r_full  <= 1'b1;
                        r_state <= c_st_full;
                    end else begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_state <= load_en ? c_st_collect : c_st_idle;
                    end
                end
                c_st_full: begin
                    r_full <= 1'b1;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Gate with rst so a reset landing on the write cycle never emits a strobe.
    assign mem_we    = r_we & ~rst;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign byte_idx  = r_byte_idx;
    assign led       = r_led;
    assign full      = r_full;

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_loader
// Brief    : Randomized and directed bench with a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_loader;

    localparam int ADDR_W  = 2;
    localparam int DB_CYC  = 16;
    localparam int N_WORDS = 1 << ADDR_W;
    localparam int HOLD    = DB_CYC + 6;

    localparam int P_IDLE    = 0;
    localparam int P_COLLECT = 1;
    localparam int P_WRITE   = 2;
    localparam int P_FULL    = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        sw;
    logic              btn;
    logic              load_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [1:0]        byte_idx;
    logic [7:0]        led;
    logic              full;

    always #5 clk = ~clk;

    inst_loader #(
        .ADDR_W (ADDR_W),
        .DB_CYC (DB_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .btn       (btn),
        .load_en   (load_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .byte_idx  (byte_idx),
        .led       (led),
        .full      (full)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit          m_s0, m_s1, m_level, m_pulse, m_p, m_same;
    bit          m_hist[$];
    int          m_phase;
    byte unsigned m_bytes[$];
    int          m_addr;
    logic [31:0] m_wdata;
    bit          m_we, m_full;
    logic [7:0]  m_led;

    always @(posedge clk) begin
        if (rst) begin
            m_s0 = 0; m_s1 = 0; m_level = 0; m_pulse = 0;
            m_hist.delete();
            m_phase = P_IDLE; m_bytes.delete(); m_addr = 0;
            m_wdata = '0; m_we = 0; m_full = 0; m_led = '0;
        end else begin
            m_p  = m_pulse;
            m_we = 0;
            case (m_phase)
                P_IDLE:    if (load_en) m_phase = P_COLLECT;
                P_COLLECT: begin
                    if (!load_en) begin
                        m_phase = P_IDLE;
                        m_bytes.delete();
                    end else if (m_p) begin
                        m_bytes.push_back(sw);
                        m_led = sw;
                        if (m_bytes.size() == 4) begin
                            m_wdata = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                            m_we    = 1;
                            m_bytes.delete();
                            m_phase = P_WRITE;
                        end
                    end
                end
                P_WRITE: begin
                    if (m_addr == N_WORDS - 1) begin
                        m_full  = 1;
                        m_phase = P_FULL;
                    end else begin
                        m_addr++;
                        m_phase = load_en ? P_COLLECT : P_IDLE;
                    end
                end
                default: ;
            endcase
            // Debounced level = value of the last DB_CYC synchronized samples when they all agree.
            m_hist.push_back(m_s1);
            if (m_hist.size() > DB_CYC) void'(m_hist.pop_front());
            m_s1 = m_s0;
            m_s0 = btn;
            m_pulse = 0;
            if (m_hist.size() == DB_CYC) begin
                m_same = 1;
                foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) m_same = 0;
                if (m_same && m_hist[0] != m_level) begin
                    m_level = m_hist[0];
                    m_pulse = m_level;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("mem_we",    {31'd0, mem_we},     {31'd0, m_we & ~rst});
            check("mem_addr",  32'(mem_addr),       32'(m_addr));
            check("mem_wdata", mem_wdata,           m_wdata);
            check("byte_idx",  32'(byte_idx),       32'(m_bytes.size()));
            check("led",       32'(led),            32'(m_led));
            check("full",      {31'd0, full},       {31'd0, m_full});
        end
    end

    // Write-strobe log for literal checks.
    int              we_count = 0;
    logic [ADDR_W-1:0] last_we_addr = '0;
    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) begin
            we_count++;
            last_we_addr = mem_addr;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] v, input int hold);
        @(negedge clk);
        sw  = v;
        btn = 1'b1;
        repeat (hold) @(negedge clk);
        btn = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    logic [7:0] vals[16];
    int         n;
    int         wc0;
    logic [7:0] last_led;

    initial begin
        rst = 1'b1; btn = 1'b0; load_en = 1'b0; sw = '0;
        cyc(3);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr",   32'(mem_addr),   32'd0);
        check("rst_wdata",  mem_wdata,       32'd0);
        check("rst_idx",    32'(byte_idx),   32'd0);
        check("rst_led",    32'(led),        32'd0);
        check("rst_full",   {31'd0, full},   32'd0);
        chk_en = 1'b1;
        rst = 1'b0;
        load_en = 1'b1;
        cyc(2);

        // Clean press: measure latency until the committed byte shows up.
        @(negedge clk);
        sw = 8'h13; btn = 1'b1; n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (byte_idx == 2'd0 && n < 100);
        check("commit_latency", 32'(n), 32'(DB_CYC + 3));
        repeat (4) @(negedge clk);
        btn = 1'b0;
        cyc(HOLD);
        check("first_led", 32'(led),      32'h13);
        check("first_idx", 32'(byte_idx), 32'd1);

        press(8'h00, HOLD); press(8'h00, HOLD); press(8'h20, HOLD);
        check("word0_data", mem_wdata,           32'h20000013);
        check("word0_addr", 32'(last_we_addr),   32'd0);
        check("word0_cnt",  32'(we_count),       32'd1);
        check("addr_after", 32'(mem_addr),       32'd1);

        // Bounce: toggle every 3 cycles, never stable long enough.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            btn = ((i / 3) % 2 == 0);
        end
        btn = 1'b0;
        cyc(HOLD);
        check("bounce_idx", 32'(byte_idx), 32'd0);
        check("bounce_led", 32'(led),      32'h20);

        // Partial word abandoned by load_en, then a fresh word.
        press(8'($urandom), HOLD); press(8'($urandom), HOLD);
        check("partial_idx", 32'(byte_idx), 32'd2);
        load_en = 1'b0;
        cyc(3);
        check("abandon_idx", 32'(byte_idx), 32'd0);
        load_en = 1'b1;
        cyc(2);
        repeat (4) press(8'hAA, HOLD);
        check("aa_data",    mem_wdata,         32'hAAAAAAAA);
        check("aa_we_addr", 32'(last_we_addr), 32'd1);
        check("aa_addr",    32'(mem_addr),     32'd2);

        // Reset landing on the write cycle, button held through reset.
        press(8'h01, HOLD); press(8'h02, HOLD); press(8'h03, HOLD);
        @(negedge clk);
        sw = 8'h04; btn = 1'b1; n = 0;
        while (!m_we && n < 100) begin
            @(negedge clk); n++;
        end
        check("write_seen", 32'(m_we), 32'd1);
        wc0 = we_count;
        rst = 1'b1;
        #1;
        check("rst_no_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        check("abort_we",    {31'd0, mem_we}, 32'd0);
        check("abort_addr",  32'(mem_addr),   32'd0);
        check("abort_wdata", mem_wdata,       32'd0);
        check("abort_idx",   32'(byte_idx),   32'd0);
        check("abort_led",   32'(led),        32'd0);
        check("abort_full",  {31'd0, full},   32'd0);
        rst = 1'b0;
        cyc(HOLD);
        btn = 1'b0;
        cyc(HOLD);
        check("held_led", 32'(led),      32'h04);
        check("held_idx", 32'(byte_idx), 32'd1);

        // Randomized traffic: glitches, boundary hold lengths, load_en drops.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                load_en = 1'b0;
                cyc($urandom_range(1, 5));
                load_en = 1'b1;
            end else begin
                press(8'($urandom), $urandom_range(1, DB_CYC + 8));
            end
        end

        // Fill all words, then one extra commit.
        do_reset();
        load_en = 1'b1;
        cyc(2);
        wc0 = we_count;
        for (int i = 0; i < 16; i++) begin
            vals[i] = 8'($urandom);
            press(vals[i], HOLD);
        end
        last_led = vals[15];
        check("fill_count", 32'(we_count - wc0), 32'(N_WORDS));
        check("fill_addr",  32'(last_we_addr),   32'(N_WORDS - 1));
        check("fill_full",  {31'd0, full},       32'd1);
        check("fill_data",  mem_wdata,           {vals[15], vals[14], vals[13], vals[12]});
        press(8'h5A, HOLD);
        check("extra_led",  32'(led),            32'(last_led));
        check("extra_cnt",  32'(we_count - wc0), 32'(N_WORDS));
        check("extra_full", {31'd0, full},       32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
